// File: rtl/instr_loader_pkg.sv
// Shared types and default sizing for the instruction loader.
// The state encoding is visible on cur_state, so the values are fixed.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 12;
    localparam int DEF_DEPTH         = 1024;

endpackage

// File: rtl/instr_loader_ram.sv
// Instruction storage: one write port and one registered read port.
// The memory array has no reset, so its contents survive a reset.
module instr_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RAM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [RAM_AW-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [RAM_AW-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: takes a stream of address/data words into local storage,
// then serves single-cycle-latency instruction fetches from that storage.
//
// state | meaning
// IDLE  | waiting for the first load session
// LOAD  | accepting words until init_last or an out-of-range address
// READY | image loaded, no fetch serviced yet
// RUN   | servicing fetches
// ERROR | load hit an out-of-range address; only init_start leaves
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DEPTH         = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_start,
    input  logic                     init_valid,
    output logic                     init_ready,
    input  logic [ADDRESS_WIDTH-1:0] init_wadrs,
    input  logic [DATA_WIDTH-1:0]    init_instruction,
    input  logic                     init_last,
    input  logic                     fetch_en,
    input  logic [ADDRESS_WIDTH-1:0] fetch_adrs,
    output logic                     fetch_valid,
    output logic [DATA_WIDTH-1:0]    fetch_instruction,
    output logic [2:0]               cur_state,
    output logic [ADDRESS_WIDTH:0]   load_count,
    output logic                     err_range
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] ONE_C   = (ADDRESS_WIDTH + 1)'(1);

    state_t                state;
    logic                  fetch_oor;
    logic                  accept;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  fetch_take;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign accept      = (state == ST_LOAD) && init_valid;
    assign wr_in_range = {1'b0, init_wadrs} < DEPTH_C;
    assign rd_in_range = {1'b0, fetch_adrs} < DEPTH_C;
    // A reload request takes priority and drops any fetch in the same cycle.
    assign fetch_take  = ((state == ST_READY) || (state == ST_RUN)) && fetch_en && !init_start;
    assign wr_en       = accept && wr_in_range;
    assign rd_en       = fetch_take && rd_in_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            load_count  <= '0;
            err_range   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_oor   <= 1'b0;
        end else begin
            fetch_valid <= fetch_take;
            fetch_oor   <= fetch_take && !rd_in_range;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (init_start) begin
                        state      <= ST_LOAD;
                        load_count <= '0;
                        err_range  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (!wr_in_range) begin
                            err_range <= 1'b1;
                            state     <= ST_ERROR;
                        end else begin
                            if (load_count != DEPTH_C) begin
                                load_count <= load_count + ONE_C;
                            end
                            if (init_last) begin
                                state <= ST_READY;
                            end
                        end
                    end
                end
                ST_READY, ST_RUN: begin
                    if (init_start) begin
                        state      <= ST_LOAD;
                        load_count <= '0;
                        err_range  <= 1'b0;
                    end else if (fetch_en) begin
                        state <= ST_RUN;
                        if (!rd_in_range) begin
                            err_range <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign init_ready        = (state == ST_LOAD);
    assign cur_state         = state;
    assign fetch_instruction = (fetch_valid && !fetch_oor) ? ram_rdata : '0;

    instr_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RAM_AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (init_wadrs[RAM_AW-1:0]),
        .wr_data (init_instruction),
        .rd_en   (rd_en),
        .rd_addr (fetch_adrs[RAM_AW-1:0]),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized bench for instr_loader against an array-based
// model of the stored image and the session rules.
module tb_instr_loader;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_start = 1'b0;
    logic          init_valid = 1'b0;
    logic          init_ready;
    logic [AW-1:0] init_wadrs = '0;
    logic [DW-1:0] init_instruction = '0;
    logic          init_last = 1'b0;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] fetch_adrs = '0;
    logic          fetch_valid;
    logic [DW-1:0] fetch_instruction;
    logic [2:0]    cur_state;
    logic [AW:0]   load_count;
    logic          err_range;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_model [DEPTH];
    bit            known [DEPTH];
    int            known_q [$];
    int            exp_count;
    bit            exp_err;

    always #5 clk = ~clk;

    instr_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .init_start        (init_start),
        .init_valid        (init_valid),
        .init_ready        (init_ready),
        .init_wadrs        (init_wadrs),
        .init_instruction  (init_instruction),
        .init_last         (init_last),
        .fetch_en          (fetch_en),
        .fetch_adrs        (fetch_adrs),
        .fetch_valid       (fetch_valid),
        .fetch_instruction (fetch_instruction),
        .cur_state         (cur_state),
        .load_count        (load_count),
        .err_range         (err_range)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        check("start_state", cur_state, 1);
        check("start_count", load_count, 0);
        check("start_err", err_range, 0);
        check("start_ready", init_ready, 1);
    endtask

    // Word that the loader must accept and store.
    task automatic load_word(input int addr, input logic [DW-1:0] data, input bit last);
        init_valid = 1'b1;
        init_wadrs = AW'(addr);
        init_instruction = data;
        init_last = last;
        tick();
        init_valid = 1'b0;
        init_last = 1'b0;
        mem_model[addr] = data;
        if (!known[addr]) begin
            known[addr] = 1'b1;
            known_q.push_back(addr);
        end
        if (exp_count < DEPTH) exp_count++;
    endtask

    task automatic fetch_one(input int addr);
        fetch_en = 1'b1;
        fetch_adrs = AW'(addr);
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic forget_all();
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        known_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int en;
        logic [DW-1:0] d;

        forget_all();
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("rst_state", cur_state, 0);
        check("rst_ready", init_ready, 0);
        check("rst_fvalid", fetch_valid, 0);
        check("rst_finstr", fetch_instruction, 0);
        check("rst_count", load_count, 0);
        check("rst_err", err_range, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic load of four words, then one fetch.
        start_session();
        for (int i = 0; i < 4; i++) begin
            load_word(i, DW'(32'hA0 + i), i == 3);
            check("l37_count", load_count, exp_count);
            check("l37_state", cur_state, (i == 3) ? 2 : 1);
        end
        fetch_one(2);
        check("f37_state", cur_state, 3);
        check("f37_valid", fetch_valid, 1);
        check("f37_data", fetch_instruction, 32'hA2);
        tick();
        check("f37_valid_drop", fetch_valid, 0);

        // Out-of-range fetch in RUN.
        fetch_one(1500);
        check("f39_valid", fetch_valid, 1);
        check("f39_data", fetch_instruction, 0);
        check("f39_err", err_range, 1);
        check("f39_state", cur_state, 3);

        // Reload from RUN; overwrite the same address twice.
        start_session();
        load_word(5, 32'h11, 1'b0);
        load_word(5, 32'h22, 1'b1);
        check("l40_count", load_count, 2);
        check("l40_state", cur_state, 2);
        fetch_one(5);
        check("f40_data", fetch_instruction, 32'h22);
        check("f40_valid", fetch_valid, 1);

        // Reload request and fetch in the same READY/RUN cycle: reload wins.
        init_start = 1'b1;
        fetch_en = 1'b1;
        fetch_adrs = AW'(0);
        tick();
        init_start = 1'b0;
        fetch_en = 1'b0;
        exp_count = 0;
        check("c42_state", cur_state, 1);
        check("c42_fvalid", fetch_valid, 0);
        check("c42_count", load_count, 0);

        // Out-of-range load address goes to ERROR without writing.
        init_valid = 1'b1;
        init_wadrs = AW'(DEPTH);
        init_instruction = 32'hDEAD_BEEF;
        tick();
        init_valid = 1'b0;
        check("e38_state", cur_state, 4);
        check("e38_err", err_range, 1);
        check("e38_ready", init_ready, 0);
        fetch_one(0);
        check("e38_fvalid", fetch_valid, 0);
        check("e38_state_hold", cur_state, 4);
        init_valid = 1'b1;
        init_wadrs = AW'(7);
        tick();
        init_valid = 1'b0;
        check("e31_state_hold", cur_state, 4);
        start_session();

        // Randomized session with idle gaps on init_valid.
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                init_wadrs = AW'($urandom_range(0, 63));
                tick();
                check("rl_gap_count", load_count, exp_count);
                check("rl_gap_state", cur_state, 1);
            end
            a = $urandom_range(0, 63);
            d = DW'($urandom);
            load_word(a, d, n == 19);
            check("rl_count", load_count, exp_count);
        end
        check("rl_state", cur_state, 2);
        check("rl_err", err_range, 0);

        exp_err = 1'b0;
        for (int n = 0; n < 40; n++) begin
            en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 7) == 0) a = DEPTH + $urandom_range(0, 3071);
            else a = known_q[$urandom_range(0, known_q.size() - 1)];
            fetch_en = en[0];
            fetch_adrs = AW'(a);
            tick();
            fetch_en = 1'b0;
            if (en != 0 && a >= DEPTH) exp_err = 1'b1;
            check("rf_valid", fetch_valid, en);
            if (en != 0) check("rf_data", fetch_instruction, (a >= DEPTH) ? 0 : mem_model[a]);
            check("rf_err", err_range, exp_err);
        end
        // The rejected ERROR-state word must not have landed at address 0.
        fetch_one(0);
        check("rf_addr0", fetch_instruction, mem_model[0]);

        // Load counter saturates at DEPTH.
        start_session();
        for (int i = 0; i < DEPTH + 6; i++) begin
            load_word(i % DEPTH, DW'($urandom), i == DEPTH + 5);
            if (i == DEPTH - 1) check("sat_full", load_count, DEPTH);
        end
        check("sat_count", load_count, DEPTH);
        check("sat_state", cur_state, 2);
        for (int n = 0; n < 6; n++) begin
            a = $urandom_range(0, DEPTH - 1);
            fetch_one(a);
            check("sat_fetch", fetch_instruction, mem_model[a]);
        end

        // Reset in the middle of a load session.
        start_session();
        load_word(10, 32'h1234, 1'b0);
        load_word(11, 32'h5678, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("r41_state", cur_state, 0);
        check("r41_count", load_count, 0);
        check("r41_ready", init_ready, 0);
        check("r41_fvalid", fetch_valid, 0);
        forget_all();
        tick();
        reset = 1'b1;
        tick();

        // Inputs in IDLE are ignored.
        init_valid = 1'b1;
        init_wadrs = AW'(3);
        fetch_en = 1'b1;
        fetch_adrs = AW'(3);
        tick();
        init_valid = 1'b0;
        fetch_en = 1'b0;
        check("i32_count", load_count, 0);
        check("i32_state", cur_state, 0);
        check("i30_fvalid", fetch_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 12: address width of load and fetch ports.
REQ-003 SHALL have parameter DEPTH, default 1024: number of instruction words stored; DEPTH <= 2**ADDRESS_WIDTH.
REQ-004 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port init_start  input  1: one-cycle pulse that begins a load session.
REQ-007 SHALL have port init_valid  input  1: load word present.
REQ-008 SHALL have port init_ready  output  1: loader accepts a word this cycle.
REQ-009 SHALL have port init_wadrs  input  ADDRESS_WIDTH: load write address.
REQ-010 SHALL have port init_instruction  input  DATA_WIDTH: load write data.
REQ-011 SHALL have port init_last  input  1: marks final word of the session.
REQ-012 SHALL have port fetch_en  input  1: processor fetch request.
REQ-013 SHALL have port fetch_adrs  input  ADDRESS_WIDTH: fetch address.
REQ-014 SHALL have port fetch_valid  output  1: fetch_instruction is valid.
REQ-015 SHALL have port fetch_instruction  output  DATA_WIDTH: fetched word.
REQ-016 SHALL have port cur_state  output  3: encoded FSM state.
REQ-017 SHALL have port load_count  output  ADDRESS_WIDTH+1: words accepted this session.
REQ-018 SHALL have port err_range  output  1: sticky out-of-range flag.

Function
REQ-019 FSM states SHALL be IDLE=0, LOAD=1, READY=2, RUN=3, ERROR=4; cur_state SHALL reflect the registered state.
REQ-020 IDLE: init_start -> LOAD next cycle, load_count cleared to 0, err_range cleared.
REQ-021 init_ready SHALL be 1 only in LOAD; a word is accepted when init_valid && init_ready.
REQ-022 Accepted word with init_wadrs < DEPTH SHALL be written; load_count increments by 1, saturating at DEPTH.
REQ-023 Repeat address in one session SHALL overwrite; load_count still increments.
REQ-024 Accepted word with init_wadrs >= DEPTH SHALL NOT be written; err_range set; state -> ERROR.
REQ-025 Accepted in-range word with init_last=1 SHALL be written, then state -> READY.
REQ-026 READY: fetch_en -> RUN; that fetch SHALL also be serviced.
REQ-027 READY/RUN: init_start -> LOAD (reload) with REQ-020 clearing; init_start wins over simultaneous fetch_en, and that fetch is dropped.
REQ-028 Fetch latency SHALL be exactly 1 cycle: fetch_en at cycle N -> fetch_valid=1 and data at N+1; fetch_valid=0 otherwise.
REQ-029 Fetch with fetch_adrs >= DEPTH SHALL return 0 with fetch_valid=1, set err_range, and remain in RUN.
REQ-030 fetch_en in IDLE, LOAD or ERROR SHALL be ignored (fetch_valid stays 0).
REQ-031 ERROR SHALL exit only on init_start -> LOAD; init_valid there is not accepted.
REQ-032 init_valid outside LOAD SHALL be ignored and SHALL NOT change load_count.

Reset
REQ-033 Reset low SHALL immediately force state IDLE, init_ready=0, fetch_valid=0, fetch_instruction=0, load_count=0, err_range=0.
REQ-034 Reset mid-LOAD SHALL abort the session; memory contents SHALL NOT be cleared and are undefined until reloaded.

Structure
REQ-035 Package instr_loader_pkg SHALL hold the state enum and default parameter constants.
REQ-036 Storage SHALL be sub-module instr_ram (one write port, one synchronous read port, DEPTH x DATA_WIDTH).

Verification
REQ-037 Load addresses 0..3 = 0xA0..0xA3 (last on 3), fetch addr 2 -> cur_state 1->2->3, load_count=4, fetch_valid and 0xA2 one cycle later.
REQ-038 Load with init_wadrs=DEPTH (1024) -> no write, err_range=1, cur_state=4; fetch_en ignored; init_start -> cur_state=1, err_range=0.
REQ-039 In RUN, fetch addr 1500 -> fetch_instruction=0, fetch_valid=1, err_range=1, cur_state stays 3.
REQ-040 Write addr 5 = 0x11 then 0x22 in one session -> load_count=2, fetch addr 5 returns 0x22.
REQ-041 Reset asserted two words into LOAD -> cur_state=0, load_count=0, init_ready=0 same cycle.
REQ-042 In READY, assert init_start and fetch_en together -> cur_state=1, fetch_valid stays 0.
